// File: rtl/prefix_adder_scheduler_if.sv
// -----------------------------------------------------------------------------
// prefix_adder_scheduler_if
// Bundles the requester, shared-adder and response channels of the
// prefix_adder_scheduler.
//   req_valid/req_ready/req_a/req_b : NREQ requesters, operand i at [i*W +: W]
//   add_a/add_b/add_sum/add_cout    : shared 8-bit adder (no carry-in)
//   resp_valid/resp_ready/resp_*    : single response channel tagged with id
// Modports: slave = scheduler side, master = environment (requesters, adder,
// response consumer).
// -----------------------------------------------------------------------------
interface prefix_adder_scheduler_if #(
  parameter int NREQ   = 4,
  parameter int NBYTES = 4
);
  localparam int W   = 8 * NBYTES;
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [7:0]        add_a;
  logic [7:0]        add_b;
  logic [7:0]        add_sum;
  logic              add_cout;
  logic              resp_valid;
  logic              resp_ready;
  logic [W-1:0]      resp_sum;
  logic              resp_cout;
  logic [IDW-1:0]    resp_id;

  modport slave (
    input  req_valid, req_a, req_b, add_sum, add_cout, resp_ready,
    output req_ready, add_a, add_b, resp_valid, resp_sum, resp_cout, resp_id
  );

  modport master (
    output req_valid, req_a, req_b, add_sum, add_cout, resp_ready,
    input  req_ready, add_a, add_b, resp_valid, resp_sum, resp_cout, resp_id
  );
endinterface

// File: rtl/prefix_adder_scheduler.sv
// -----------------------------------------------------------------------------
// prefix_adder_scheduler
// Round-robin arbiter and byte sequencer for one shared 8-bit adder without
// carry-in. Each accepted request is added one byte per pass (ADD); a byte
// with an incoming carry gets a second pass adding 8'h01 (INC). The full sum,
// carry-out and requester id are held on the response channel until accepted.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   bus_io : prefix_adder_scheduler_if.slave (request, adder, response)
// -----------------------------------------------------------------------------
module prefix_adder_scheduler #(
  parameter int NREQ   = 4,
  parameter int NBYTES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  prefix_adder_scheduler_if.slave        bus_io
);
  localparam int W   = 8 * NBYTES;
  localparam int IDW = $clog2(NREQ);
  localparam int KW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [KW-1:0]  K_LAST  = KW'(NBYTES - 1);
  localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_INC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [KW-1:0]  k_q, k_d;
  logic           cin_q, cin_d;
  logic           c1_q, c1_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic [7:0]     add_a_q, add_a_d;
  logic [7:0]     add_b_q, add_b_d;

  logic           win_found_s;
  logic [IDW-1:0] win_idx_s;
  logic [NREQ-1:0] req_ready_s;
  logic [KW-1:0]  k_nxt_s;

  assign k_nxt_s = k_q + KW'(1);

  // Round-robin search: first valid at or above ptr, then wrap below ptr.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found_s && bus_io.req_valid[i] && (IDW'(i) >= ptr_q)) begin
        win_found_s = 1'b1;
        win_idx_s   = IDW'(i);
      end else begin
        win_found_s = win_found_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found_s && bus_io.req_valid[i] && (IDW'(i) < ptr_q)) begin
        win_found_s = 1'b1;
        win_idx_s   = IDW'(i);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Grant is combinational in IDLE and suppressed while reset is asserted.
  always_comb begin
    req_ready_s = '0;
    if (!rst && (state_q == ST_IDLE) && win_found_s) begin
      req_ready_s[win_idx_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // Next-state logic: arbitration, byte passes and response hold.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    k_d     = k_q;
    cin_d   = cin_q;
    c1_d    = c1_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    add_a_d = 8'h00;
    add_b_d = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          a_d     = bus_io.req_a[int'(win_idx_s)*W +: W];
          b_d     = bus_io.req_b[int'(win_idx_s)*W +: W];
          id_d    = win_idx_s;
          ptr_d   = (win_idx_s == ID_LAST) ? IDW'(0) : win_idx_s + IDW'(1);
          k_d     = KW'(0);
          cin_d   = 1'b0;
          c1_d    = 1'b0;
          add_a_d = bus_io.req_a[int'(win_idx_s)*W +: 8];
          add_b_d = bus_io.req_b[int'(win_idx_s)*W +: 8];
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        sum_d[int'(k_q)*8 +: 8] = bus_io.add_sum;
        c1_d = bus_io.add_cout;
        // Byte 0 never has a carry-in, so the k check only guards stale cin.
        if ((k_q != KW'(0)) && cin_q) begin
          add_a_d = bus_io.add_sum;
          add_b_d = 8'h01;
          state_d = ST_INC;
        end else begin
          cin_d = bus_io.add_cout;
          if (k_q == K_LAST) begin
            state_d = ST_DONE;
          end else begin
            k_d     = k_nxt_s;
            add_a_d = a_q[int'(k_nxt_s)*8 +: 8];
            add_b_d = b_q[int'(k_nxt_s)*8 +: 8];
            state_d = ST_ADD;
          end
        end
      end
      ST_INC: begin
        sum_d[int'(k_q)*8 +: 8] = bus_io.add_sum;
        // A+B <= 0x1FE, so the +1 pass can only carry when pass 1 did not.
        cin_d = c1_q | bus_io.add_cout;
        if (k_q == K_LAST) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_nxt_s;
          add_a_d = a_q[int'(k_nxt_s)*8 +: 8];
          add_b_d = b_q[int'(k_nxt_s)*8 +: 8];
          state_d = ST_ADD;
        end
      end
      ST_DONE: begin
        if (bus_io.resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      k_q     <= '0;
      cin_q   <= 1'b0;
      c1_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      add_a_q <= 8'h00;
      add_b_q <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      k_q     <= k_d;
      cin_q   <= cin_d;
      c1_q    <= c1_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
    end
  end

  // After the last pass cin holds the carry out of bit W-1.
  assign bus_io.req_ready  = req_ready_s;
  assign bus_io.add_a      = add_a_q;
  assign bus_io.add_b      = add_b_q;
  assign bus_io.resp_valid = (state_q == ST_DONE);
  assign bus_io.resp_sum   = sum_q;
  assign bus_io.resp_cout  = cin_q;
  assign bus_io.resp_id    = id_q;

endmodule

// File: tb/tb_prefix_adder_scheduler.sv
// -----------------------------------------------------------------------------
// tb_prefix_adder_scheduler
// Scoreboard bench: accepts observed on the request channel push expected
// responses and adder passes; a negedge monitor compares every cycle.
// -----------------------------------------------------------------------------
module tb_prefix_adder_scheduler;
  localparam int NREQ   = 4;
  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic clk = 1'b0;
  logic rst = 1'b1;

  prefix_adder_scheduler_if #(.NREQ(NREQ), .NBYTES(NBYTES)) bus();

  prefix_adder_scheduler #(.NREQ(NREQ), .NBYTES(NBYTES)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  // Shared adder: 8-bit, no carry-in, purely combinational.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b};

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        cout;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] pass_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          model_ptr = 0;
  int          stim_to = 0;
  int          seen_to = 0;
  logic        in_resp = 1'b0;
  logic [31:0] dir_a[4];
  logic [31:0] dir_b[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Reference: sum by plain addition; pass list and carry count from the
  // carry into each byte computed on the truncated low-order operands.
  task automatic push_exp(input int id, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] full;
    logic [63:0] a64, b64, mk, lo;
    logic [7:0]  ab, bb;
    int          kcnt;
    full = {1'b0, a} + {1'b0, b};
    kcnt = 0;
    for (int k = 0; k < NBYTES; k++) begin
      a64 = 64'(a) >> (8 * k);
      b64 = 64'(b) >> (8 * k);
      ab  = a64[7:0];
      bb  = b64[7:0];
      pass_q.push_back({ab, bb});
      mk  = (64'd1 << (8 * k)) - 64'd1;
      lo  = ((64'(a) & mk) + (64'(b) & mk)) >> (8 * k);
      if (k >= 1 && lo != 64'd0) begin
        pass_q.push_back({ab + bb, 8'h01});
        kcnt++;
      end
    end
    e.id   = 2'(id);
    e.sum  = full[31:0];
    e.cout = full[32];
    e.acc  = cyc;
    e.lat  = 1 + NBYTES + kcnt;
    exp_q.push_back(e);
  endtask

  // Monitor: adder passes, response timing/content/stability, arbitration.
  always @(negedge clk) begin
    logic        busy;
    logic [3:0]  exp_rdy;
    logic [3:0]  acc;
    int          win;
    int          j;
    int          id;
    cyc++;
    chk("stim_timeout", 64'(stim_to), 64'(seen_to));
    seen_to = stim_to;
    if (rst) begin
      exp_q.delete();
      pass_q.delete();
      in_resp   = 1'b0;
      model_ptr = 0;
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_resp_sum", 64'(bus.resp_sum), 64'd0);
      chk("rst_resp_cout", 64'(bus.resp_cout), 64'd0);
      chk("rst_resp_id", 64'(bus.resp_id), 64'd0);
      chk("rst_add_ab", 64'({bus.add_a, bus.add_b}), 64'd0);
    end else begin
      if (pass_q.size() > 0) begin
        chk("add_pass", 64'({bus.add_a, bus.add_b}), 64'(pass_q[0]));
        void'(pass_q.pop_front());
      end else begin
        chk("add_idle", 64'({bus.add_a, bus.add_b}), 64'd0);
      end
      busy = (exp_q.size() > 0);
      if (in_resp) begin
        chk("resp_hold_valid", 64'(bus.resp_valid), 64'd1);
        chk("resp_hold_sum", 64'(bus.resp_sum), 64'(exp_q[0].sum));
        chk("resp_hold_cout", 64'(bus.resp_cout), 64'(exp_q[0].cout));
        chk("resp_hold_id", 64'(bus.resp_id), 64'(exp_q[0].id));
      end else if (busy) begin
        if (cyc - exp_q[0].acc < exp_q[0].lat) begin
          chk("resp_early", 64'(bus.resp_valid), 64'd0);
        end else begin
          chk("resp_latency", 64'(bus.resp_valid), 64'd1);
          if (bus.resp_valid) begin
            in_resp = 1'b1;
            chk("resp_sum", 64'(bus.resp_sum), 64'(exp_q[0].sum));
            chk("resp_cout", 64'(bus.resp_cout), 64'(exp_q[0].cout));
            chk("resp_id", 64'(bus.resp_id), 64'(exp_q[0].id));
          end
        end
      end else begin
        chk("resp_spurious", 64'(bus.resp_valid), 64'd0);
      end
      if (in_resp && bus.resp_valid && bus.resp_ready) begin
        in_resp = 1'b0;
        void'(exp_q.pop_front());
      end
      exp_rdy = 4'b0000;
      win = -1;
      if (!busy) begin
        for (int i = 0; i < NREQ; i++) begin
          j = (model_ptr + i) % NREQ;
          if (win < 0 && bus.req_valid[j]) win = j;
        end
      end
      if (win >= 0) exp_rdy[win] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      acc = bus.req_valid & bus.req_ready;
      if (acc != 4'b0000) begin
        id = -1;
        for (int i = 0; i < NREQ; i++) begin
          if (id < 0 && acc[i]) id = i;
        end
        model_ptr = (id + 1) % NREQ;
        push_exp(id, bus.req_a[id*W +: W], bus.req_b[id*W +: W]);
      end
    end
  end

  task automatic drive_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  // Operands biased toward long carry chains and short ones.
  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 3))
      0:       v = v | 32'hFFFFFF00;
      1:       v = v & 32'h000000FF;
      default: v = v;
    endcase
    return v;
  endfunction

  // Serve every requester in mask `rounds` times; bp>0 holds resp_ready low
  // for bp cycles after each response appears.
  task automatic run_batch(input logic [3:0] mask, input int rounds, input int bp, input bit use_dir);
    int         left[4];
    int         remaining;
    int         outstanding;
    int         budget;
    int         held;
    logic [3:0] acc;
    logic       rv;
    logic       hs;
    remaining = 0;
    outstanding = 0;
    budget = 0;
    held = 0;
    for (int i = 0; i < NREQ; i++) begin
      left[i] = mask[i] ? rounds : 0;
      remaining += left[i];
      if (mask[i]) begin
        if (use_dir) drive_ops(i, dir_a[i], dir_b[i]);
        else drive_ops(i, rnd_op(), rnd_op());
        bus.req_valid[i] = 1'b1;
      end
    end
    bus.resp_ready = (bp == 0);
    while ((remaining > 0 || outstanding > 0) && budget < 2000) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      rv  = bus.resp_valid;
      hs  = bus.resp_valid & bus.resp_ready;
      @(posedge clk);
      #1;
      budget++;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          outstanding++;
          remaining--;
          left[i]--;
          if (left[i] > 0) drive_ops(i, rnd_op(), rnd_op());
          else bus.req_valid[i] = 1'b0;
        end
      end
      if (hs) begin
        outstanding--;
        held = 0;
        if (bp > 0) bus.resp_ready = 1'b0;
      end else if (rv && bp > 0) begin
        held++;
        if (held >= bp) bus.resp_ready = 1'b1;
      end
    end
    if (budget >= 2000) begin
      stim_to++;
      bus.req_valid = 4'b0000;
    end
    bus.resp_ready = 1'b1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int budget;
    bus.req_valid  = 4'b0000;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // No carries: latency NBYTES+1.
    dir_a[0] = 32'h12345678; dir_b[0] = 32'h11111111;
    run_batch(4'b0001, 1, 0, 1'b1);
    // Full ripple: three INC passes.
    dir_a[0] = 32'hFFFFFFFF; dir_b[0] = 32'h00000001;
    run_batch(4'b0001, 1, 0, 1'b1);
    // Alternating carries out of each pass 1.
    dir_a[0] = 32'h80808080; dir_b[0] = 32'h80808080;
    run_batch(4'b0001, 1, 0, 1'b1);

    // Round-robin from a fresh pointer with everyone requesting.
    reset_pulse();
    run_batch(4'b1111, 2, 0, 1'b0);

    // Backpressure with a competing requester waiting.
    run_batch(4'b0011, 1, 10, 1'b0);

    // Asynchronous reset during the byte-2 INC pass of requester 2.
    drive_ops(2, 32'h80808080, 32'h80808080);
    bus.req_valid[2] = 1'b1;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!bus.req_ready[2] && budget < 50);
    @(posedge clk);
    #1 bus.req_valid[2] = 1'b0;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (bus.add_b !== 8'h01 && budget < 50);
    if (budget >= 50) stim_to++;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    drive_ops(0, rnd_op(), rnd_op());
    drive_ops(2, rnd_op(), rnd_op());
    bus.req_valid = 4'b0101;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_batch(4'b0101, 1, 0, 1'b0);

    // Random traffic.
    for (int t = 0; t < 25; t++) begin
      run_batch(4'($urandom_range(1, 15)), $urandom_range(1, 3),
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
